// File: rtl/regfile_2w2r_scoreboard.sv
// Two-write / two-read register file with write-first bypass and a per-register pending
// scoreboard for multi-cycle loads. Define ZERO_REG_EN to hardwire register 0 to zero.
module regfile_2w2r_scoreboard #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Write_En,
  input  logic [ADDR_W-1:0]        Write_Addr,
  input  logic [DATA_W-1:0]        Write_Data,
  input  logic                     Write_En_L,
  input  logic [ADDR_W-1:0]        Write_Addr_L,
  input  logic [DATA_W-1:0]        Write_Data_L,
  input  logic                     Lock_En,
  input  logic [ADDR_W-1:0]        Lock_Addr,
  input  logic [ADDR_W-1:0]        Read_Addr_A,
  input  logic [ADDR_W-1:0]        Read_Addr_B,
  output logic [DATA_W-1:0]        OutA,
  output logic [DATA_W-1:0]        OutB,
  output logic                     Busy_A,
  output logic                     Busy_B,
  output logic [(2**ADDR_W)-1:0]   Pending
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       r_regs [DEPTH];
  logic [DEPTH-1:0]        r_pending;
  logic                    w_we0;
  logic                    w_we1;
  logic                    w_lock;
  logic [DEPTH-1:0]        w_wr_hit;
  logic [DEPTH-1:0]        w_lock_hit;
  logic [1:0][ADDR_W-1:0]  w_raddr;

  // Enables are masked by rst so the bypass cannot leak write data while in reset.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    w_we0  = Write_En   & ~rst;
    w_we1  = Write_En_L & ~rst;
    w_lock = Lock_En    & ~rst;
`ifdef ZERO_REG_EN
    if (Write_Addr   == '0) w_we0  = 1'b0;
    if (Write_Addr_L == '0) w_we1  = 1'b0;
    if (Lock_Addr    == '0) w_lock = 1'b0;
`endif
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wr_hit[i]   = (w_we0 && (Write_Addr   == ADDR_W'(i))) ||
                      (w_we1 && (Write_Addr_L == ADDR_W'(i)));
      w_lock_hit[i] = w_lock && (Lock_Addr == ADDR_W'(i));
    end
  end

  // NOTE: the storage is a bank of flops rather than a RAM macro, so it can take the async reset.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RESET_VAL;
      r_pending <= '0;
    end else begin
      if (w_we0) r_regs[Write_Addr] <= Write_Data;
      // Port 1 is assigned last so a load wins a same-address collision.
      if (w_we1) r_regs[Write_Addr_L] <= Write_Data_L;
      // A new lock beats a same-cycle clear because it marks a freshly issued load.
      r_pending <= w_lock_hit | (r_pending & ~w_wr_hit);
    end
  end

  assign w_raddr = {Read_Addr_B, Read_Addr_A};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    always_comb begin
      if (w_we1 && (Write_Addr_L == w_raddr[p]))    w_data = Write_Data_L;
      else if (w_we0 && (Write_Addr == w_raddr[p])) w_data = Write_Data;
      else                                          w_data = r_regs[w_raddr[p]];
      // A same-cycle write forwards its data, so the register is no longer a hazard.
      w_busy = r_pending[w_raddr[p]] && !w_wr_hit[w_raddr[p]];
`ifdef ZERO_REG_EN
      if (w_raddr[p] == '0) begin
        w_data = '0;
        w_busy = 1'b0;
      end
`endif
    end
  end

  assign OutA    = g_rd[0].w_data;
  assign OutB    = g_rd[1].w_data;
  assign Busy_A  = g_rd[0].w_busy;
  assign Busy_B  = g_rd[1].w_busy;
  assign Pending = r_pending;

endmodule

// File: tb/tb_regfile_2w2r_scoreboard.sv
// Self-checking bench for regfile_2w2r_scoreboard: directed vector table, hand-written
// reset/zero-register sequences and randomized traffic against a behavioural model.
module tb_regfile_2w2r_scoreboard;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             we, wel, lk;
  logic [AW-1:0]    wa, wal, la, ra, rb;
  logic [DW-1:0]    wd, wdl;
  logic [DW-1:0]    out_a, out_b;
  logic             busy_a, busy_b;
  logic [DEPTH-1:0] pending;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] mdl_regs [DEPTH];
  bit            mdl_pend [DEPTH];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          wel;
    logic [AW-1:0] wal;
    logic [DW-1:0] wdl;
    logic          lk;
    logic [AW-1:0] la;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          eba;
    logic          ebb;
    logic [7:0]    ep;
  } vec_t;

  vec_t vecs [23];

  always #5 clk = ~clk;

  regfile_2w2r_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .Write_En     (we),
    .Write_Addr   (wa),
    .Write_Data   (wd),
    .Write_En_L   (wel),
    .Write_Addr_L (wal),
    .Write_Data_L (wdl),
    .Lock_En      (lk),
    .Lock_Addr    (la),
    .Read_Addr_A  (ra),
    .Read_Addr_B  (rb),
    .OutA         (out_a),
    .OutB         (out_b),
    .Busy_A       (busy_a),
    .Busy_B       (busy_b),
    .Pending      (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic v_we, input int v_wa, input logic [DW-1:0] v_wd,
                              input logic v_wel, input int v_wal, input logic [DW-1:0] v_wdl,
                              input logic v_lk, input int v_la, input int v_ra, input int v_rb,
                              input logic [DW-1:0] v_ea, input logic [DW-1:0] v_eb,
                              input logic v_eba, input logic v_ebb, input logic [7:0] v_ep);
    vec_t v;
    v.we = v_we;   v.wa = AW'(v_wa);   v.wd = v_wd;
    v.wel = v_wel; v.wal = AW'(v_wal); v.wdl = v_wdl;
    v.lk = v_lk;   v.la = AW'(v_la);
    v.ra = AW'(v_ra); v.rb = AW'(v_rb);
    v.ea = v_ea; v.eb = v_eb; v.eba = v_eba; v.ebb = v_ebb; v.ep = v_ep;
    return v;
  endfunction

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    wel = 1'b0; wal = '0; wdl = '0;
    lk = 1'b0; la = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_regs[i] = '0;
      mdl_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (ZERO && a == 0) return '0;
    if (wel && wal == a) return wdl;
    if (we && wa == a) return wd;
    return mdl_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (ZERO && a == 0) return 1'b0;
    return mdl_pend[a] && !((we && wa == a) || (wel && wal == a));
  endfunction

  function automatic logic [DEPTH-1:0] exp_pending();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = mdl_pend[i];
    return v;
  endfunction

  // Applies one rising edge worth of the register-file rules to the model.
  task automatic model_clock();
    bit hit [DEPTH];
    for (int i = 0; i < DEPTH; i++)
      hit[i] = ((we && wa == i) || (wel && wal == i)) && !(ZERO && i == 0);
    if (we && !(ZERO && wa == 0))   mdl_regs[wa]  = wd;
    if (wel && !(ZERO && wal == 0)) mdl_regs[wal] = wdl;
    for (int i = 0; i < DEPTH; i++) begin
      if (lk && la == i && !(ZERO && i == 0)) mdl_pend[i] = 1'b1;
      else if (hit[i])                        mdl_pend[i] = 1'b0;
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input int idx);
    vec_t v;
    logic [DW-1:0] ea, eb;
    logic eba, ebb;
    logic [7:0] ep;
    v = vecs[idx];
    we = v.we; wa = v.wa; wd = v.wd;
    wel = v.wel; wal = v.wal; wdl = v.wdl;
    lk = v.lk; la = v.la; ra = v.ra; rb = v.rb;
    #1;
    ea = v.ea; eb = v.eb; eba = v.eba; ebb = v.ebb; ep = v.ep;
    if (ZERO && v.ra == 0) begin ea = '0; eba = 1'b0; end
    if (ZERO && v.rb == 0) begin eb = '0; ebb = 1'b0; end
    if (ZERO) ep[0] = 1'b0;
    check($sformatf("row%0d_outa", idx), 32'(out_a), 32'(ea));
    check($sformatf("row%0d_outb", idx), 32'(out_b), 32'(eb));
    check($sformatf("row%0d_busya", idx), 32'(busy_a), 32'(eba));
    check($sformatf("row%0d_busyb", idx), 32'(busy_b), 32'(ebb));
    check($sformatf("row%0d_pending", idx), 32'(pending), 32'(ep));
    step();
  endtask

  initial begin
    logic [DW-1:0] exp_sw [8];
    exp_sw = '{16'h0012, 16'h0034, 16'h0056, 16'h0078, 16'h009A, 16'h00BC, 16'h0000, 16'h0000};

    //           we wa  wd        wel wal wdl       lk la ra rb  ea        eb        ba bb pend
    vecs[0]  = mk(1, 0, 16'h0012, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0012, 16'h0000, 0, 0, 8'h00);
    vecs[1]  = mk(1, 1, 16'h0034, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0012, 16'h0034, 0, 0, 8'h00);
    vecs[2]  = mk(1, 2, 16'h0056, 0, 0, 16'h0000, 0, 0, 1, 2, 16'h0034, 16'h0056, 0, 0, 8'h00);
    vecs[3]  = mk(1, 3, 16'h0078, 0, 0, 16'h0000, 0, 0, 2, 3, 16'h0056, 16'h0078, 0, 0, 8'h00);
    vecs[4]  = mk(1, 4, 16'h009A, 0, 0, 16'h0000, 0, 0, 3, 4, 16'h0078, 16'h009A, 0, 0, 8'h00);
    vecs[5]  = mk(1, 5, 16'h00BC, 0, 0, 16'h0000, 0, 0, 4, 5, 16'h009A, 16'h00BC, 0, 0, 8'h00);
    vecs[6]  = mk(1, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0, 3, 3, 16'h5555, 16'h5555, 0, 0, 8'h00);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 5, 16'h5555, 16'h00BC, 0, 0, 8'h00);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 4, 4, 16'h009A, 16'h009A, 0, 0, 8'h00);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 4, 16'h009A, 16'h009A, 1, 1, 8'h10);
    vecs[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 4, 16'h009A, 16'h009A, 1, 1, 8'h10);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 4, 16'h009A, 16'h009A, 1, 1, 8'h10);
    vecs[12] = mk(0, 0, 16'h0000, 1, 4, 16'hBEEF, 0, 0, 4, 0, 16'hBEEF, 16'h0012, 0, 0, 8'h10);
    vecs[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 4, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00);
    vecs[14] = mk(0, 0, 16'h0000, 1, 2, 16'h2222, 1, 2, 2, 2, 16'h2222, 16'h2222, 0, 0, 8'h00);
    vecs[15] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h2222, 16'h0012, 1, 0, 8'h04);
    vecs[16] = mk(1, 2, 16'h3333, 0, 0, 16'h0000, 0, 0, 2, 1, 16'h3333, 16'h0034, 0, 0, 8'h04);
    vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 2, 16'h3333, 16'h3333, 0, 0, 8'h00);
    vecs[18] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 5, 16'h00BC, 16'h00BC, 0, 0, 8'h00);
    vecs[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 5, 16'h00BC, 16'h00BC, 1, 1, 8'h20);
    vecs[20] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 5, 16'h00BC, 16'h00BC, 1, 1, 8'h20);
    vecs[21] = mk(0, 0, 16'h0000, 1, 5, 16'h0BCD, 0, 0, 5, 6, 16'h0BCD, 16'h0000, 0, 0, 8'h20);
    vecs[22] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 6, 16'h0BCD, 16'h0000, 0, 0, 8'h00);

    // Reset, with a write enable held high to show it is ignored.
    rst = 1'b1;
    idle();
    we = 1'b1; wa = 3'd2; wd = 16'hFFFF;
    ra = 3'd2; rb = 3'd7;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_outa", 32'(out_a), 32'h0);
    check("rst_outb", 32'(out_b), 32'h0);
    check("rst_busya", 32'(busy_a), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    idle();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_row(i);

    for (int i = 0; i < 8; i++) begin
      idle();
      ra = AW'(i);
      rb = AW'(7 - i);
      #1;
      check($sformatf("sweep_a%0d", i), 32'(out_a), (ZERO && i == 0) ? 32'h0 : 32'(exp_sw[i]));
      check($sformatf("sweep_b%0d", 7 - i), 32'(out_b), 32'(exp_sw[7 - i]));
      step();
    end

    for (int i = 6; i < 23; i++) run_row(i);

    // Fill regs 6/7, lock everything, then assert reset mid-cycle.
    idle(); we = 1'b1; wa = 3'd6; wd = 16'h6666; step();
    wa = 3'd7; wd = 16'h7777; step();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      lk = 1'b1; la = AW'(i); step();
    end
    idle();
    ra = 3'd3; rb = 3'd6;
    #1;
    check("pre_rst_pending", 32'(pending), ZERO ? 32'hFE : 32'hFF);
    check("pre_rst_outb", 32'(out_b), 32'h6666);
    check("pre_rst_busyb", 32'(busy_b), 32'h1);
    we = 1'b1; wa = 3'd3; wd = 16'hFFFF;
    #1 rst = 1'b1;
    #1;
    check("async_rst_pending", 32'(pending), 32'h0);
    check("async_rst_outa", 32'(out_a), 32'h0);
    check("async_rst_outb", 32'(out_b), 32'h0);
    check("async_rst_busya", 32'(busy_a), 32'h0);
    check("async_rst_busyb", 32'(busy_b), 32'h0);
    idle();
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Register 0 write + lock: hardwired zero or ordinary register depending on the build.
    idle();
    we = 1'b1; wa = 3'd0; wd = 16'h1234;
    lk = 1'b1; la = 3'd0;
    ra = 3'd0; rb = 3'd1;
    #1;
    check("zr_during_outa", 32'(out_a), ZERO ? 32'h0 : 32'h1234);
    check("zr_during_busya", 32'(busy_a), 32'h0);
    step();
    idle();
    ra = 3'd0;
    #1;
    check("zr_after_outa", 32'(out_a), ZERO ? 32'h0 : 32'h1234);
    check("zr_after_busya", 32'(busy_a), ZERO ? 32'h0 : 32'h1);
    check("zr_after_pending", 32'(pending), ZERO ? 32'h0 : 32'h1);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, DEPTH - 1));
      wd  = DW'($urandom);
      wel = ($urandom_range(0, 2) == 0);
      wal = AW'($urandom_range(0, DEPTH - 1));
      wdl = DW'($urandom);
      lk  = ($urandom_range(0, 3) == 0);
      la  = AW'($urandom_range(0, DEPTH - 1));
      ra  = AW'($urandom_range(0, DEPTH - 1));
      rb  = AW'($urandom_range(0, DEPTH - 1));
      #1;
      check($sformatf("rnd%0d_outa", n), 32'(out_a), 32'(exp_read(ra)));
      check($sformatf("rnd%0d_outb", n), 32'(out_b), 32'(exp_read(rb)));
      check($sformatf("rnd%0d_busya", n), 32'(busy_a), 32'(exp_busy(ra)));
      check($sformatf("rnd%0d_busyb", n), 32'(busy_b), 32'(exp_busy(rb)));
      check($sformatf("rnd%0d_pending", n), 32'(pending), 32'(exp_pending()));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_scoreboard.md
Name: regfile_2w2r_scoreboard

Overview:
Parametrised successor to the 8x16 single-write register file, for the single-cycle RISC datapath. It provides two write ports (port 0 for ALU writeback, port 1 for late load writeback) and two combinational read ports with write-first bypass. A per-register pending scoreboard lets the controller lock a destination register for a multi-cycle load and detect read-after-write hazards.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (derived localparam, not overridable)
RESET_VAL, 0, value loaded into every register on reset (DATA_W bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
Write_En  input  1  write port 0 enable
Write_Addr  input  ADDR_W  write port 0 address
Write_Data  input  DATA_W  write port 0 data
Write_En_L  input  1  write port 1 (load) enable
Write_Addr_L  input  ADDR_W  write port 1 address
Write_Data_L  input  DATA_W  write port 1 data
Lock_En  input  1  mark Lock_Addr pending
Lock_Addr  input  ADDR_W  register to lock
Read_Addr_A  input  ADDR_W  read port A address
Read_Addr_B  input  ADDR_W  read port B address
OutA  output  DATA_W  read data A
OutB  output  DATA_W  read data B
Busy_A  output  1  Read_Addr_A register pending
Busy_B  output  1  Read_Addr_B register pending
Pending  output  DEPTH  raw scoreboard vector, bit i = register i pending

Behaviour:
- Reset (async, takes effect immediately): all registers = RESET_VAL, Pending = 0. OutA/OutB = RESET_VAL, Busy_A/B = 0 while rst is held high. Enables are ignored during reset.
- Writes: on the rising edge, a port with its enable high writes its data to its address.
- Write collision: if both ports are enabled to the same address, port 1 (load) wins and the port 0 data is discarded.
- Reads are combinational with write-first bypass. Per read port:
  - If Write_En_L is high and Write_Addr_L matches, output Write_Data_L.
  - Else if Write_En is high and Write_Addr matches, output Write_Data.
  - Else output the stored value.
  - The priority order matches the collision rule.
- Scoreboard, next state per register i:
  - Set if Lock_En is high and Lock_Addr == i.
  - Else cleared if either write port writes i.
  - Else held.
  - Lock beats a same-cycle clear, because a new load is issued.
- Locking an already-pending register keeps it pending. It is not an error.
- Busy_X = Pending[Read_Addr_X] AND NOT (any write port writing Read_Addr_X this cycle). The same-cycle clear is bypassed, so a dependent read gets the forwarded data with Busy low.
- Busy_X ignores a same-cycle Lock. The lock takes effect from the next cycle.
- Port 0 writing a pending register performs the write and clears Pending. The controller must not do this; no check is made.
- The pending state survives any number of cycles. Only rst or a write clears it.
- All address arithmetic is exact ADDR_W bits, with no wrap-around beyond DEPTH-1.
- Latency: write-to-stored is 1 cycle. Write-to-read is 0 cycles via the bypass.

Optional Feature:
Macro ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0 and never written.
  - Reads of address 0 return 0 even if a port is writing 0 (no bypass for 0).
  - Lock of address 0 is ignored, so Pending[0] is constantly 0 and Busy is never high for address 0.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset with RESET_VAL=16'h0000, then write 0x12,0x34,0x56,0x78,0x9A,0xBC to addresses 0-5 via port 0. Sweep Read_Addr_A 0-7 -> 0x12..0xBC at 0-5 and 0x0000 at 6-7. Sweep Read_Addr_B 0-7 -> same values.
- Same-cycle collision: Write_En=1, Write_Addr=3, Write_Data=0xAAAA; Write_En_L=1, Write_Addr_L=3, Write_Data_L=0x5555; Read_Addr_A=3 -> OutA=0x5555 in the same cycle, and reg 3 holds 0x5555 after the edge.
- Lock reg 4, then read 4 for 3 idle cycles -> Busy_A=1 and Pending=8'b0001_0000. Then Write_En_L=1, addr 4, data 0xBEEF -> Busy_A=0 and OutA=0xBEEF in that cycle, and Pending=0 next cycle.
- Lock_En on addr 2 in the same cycle as Write_En_L to addr 2 -> reg 2 = new data and Pending[2]=1 after the edge.
- Assert rst asynchronously mid-cycle while Pending=8'hFF and registers are nonzero -> Pending=0 and OutA/OutB=0x0000 immediately, without waiting for a clock edge.
- With ZERO_REG_EN defined: write 0x1234 to addr 0 and lock addr 0 -> OutA at addr 0 = 0x0000 during and after the write, and Busy_A=0. With the macro undefined: OutA=0x1234 and Busy_A=1 after the edge.
